cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) between NUM_REQ result producers (functional units).

---
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 tb/tb_cdb_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants one of NUM_REQ result producers per cycle onto the single
// common data bus and registers the winner's tag/data/index with one cycle of latency.
// Build option: define CDB_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins
// priority (no round-robin pointer); the default build is round-robin.
module cdb_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 4,
  parameter int CDB_TAG_WIDTH = 4,
  parameter int SRC_WIDTH     = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*CDB_TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              cdb_stall,
  output logic                              cdb_valid,
  output logic [CDB_TAG_WIDTH-1:0]          cdb_tag,
  output logic [DATA_WIDTH-1:0]             cdb_data,
  output logic [SRC_WIDTH-1:0]              cdb_src
);

  logic                     gnt_any_p0;
  logic [SRC_WIDTH-1:0]     gnt_idx_p0;
  logic                     gnt_ok_p0;
  logic [CDB_TAG_WIDTH-1:0] sel_tag_p0;
  logic [DATA_WIDTH-1:0]    sel_data_p0;

  logic                     vld_p1;
  logic [CDB_TAG_WIDTH-1:0] tag_p1;
  logic [DATA_WIDTH-1:0]    data_p1;
  logic [SRC_WIDTH-1:0]     src_p1;

`ifdef CDB_ARB_FIXED_PRIORITY_EN
  // Fixed priority: scan from the top down so the lowest valid index is written last and wins.
  always_comb begin
    gnt_any_p0 = 1'b0;
    gnt_idx_p0 = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_any_p0 = 1'b1;
        gnt_idx_p0 = SRC_WIDTH'(i);
      end
    end
  end
`else
  logic [SRC_WIDTH-1:0] rr_ptr;
  logic [SRC_WIDTH:0]   rr_sum;

  // Round-robin: scan offsets from rr_ptr downwards so the smallest offset (first hit
  // in ascending wrapped order) is written last and wins.
  always_comb begin
    gnt_any_p0 = 1'b0;
    gnt_idx_p0 = '0;
    rr_sum     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      rr_sum = {1'b0, rr_ptr} + (SRC_WIDTH+1)'(k);
      if (rr_sum >= (SRC_WIDTH+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (SRC_WIDTH+1)'(NUM_REQ);
      end
      if (req_valid[rr_sum[SRC_WIDTH-1:0]]) begin
        gnt_any_p0 = 1'b1;
        gnt_idx_p0 = rr_sum[SRC_WIDTH-1:0];
      end
    end
  end

  // Pointer moves one past the winner (wrapping); holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_ok_p0) begin
      if (int'(gnt_idx_p0) == NUM_REQ - 1) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= gnt_idx_p0 + 1'b1;
      end
    end
  end
`endif

  // Grant is suppressed while stalled or while reset is asserted.
  assign gnt_ok_p0 = gnt_any_p0 & ~cdb_stall & rst_n;
  assign req_ready = gnt_ok_p0 ? (NUM_REQ'(1) << gnt_idx_p0) : '0;

  // Pick the winner's payload out of the packed request buses.
  always_comb begin
    sel_tag_p0  = '0;
    sel_data_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (SRC_WIDTH'(i) == gnt_idx_p0) begin
        sel_tag_p0  = req_tag[i*CDB_TAG_WIDTH +: CDB_TAG_WIDTH];
        sel_data_p0 = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---- p0 -> p1: broadcast register; payload holds its last value on idle cycles ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      tag_p1  <= '0;
      data_p1 <= '0;
      src_p1  <= '0;
    end else begin
      vld_p1 <= gnt_ok_p0;
      if (gnt_ok_p0) begin
        tag_p1  <= sel_tag_p0;
        data_p1 <= sel_data_p0;
        src_p1  <= gnt_idx_p0;
      end
    end
  end

  assign cdb_valid = vld_p1;
  assign cdb_tag   = tag_p1;
  assign cdb_data  = data_p1;
  assign cdb_src   = src_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors for cdb_arbiter with a scoreboard queue of expected
// CDB broadcasts drained by an independent monitor.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_tag;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        cdb_stall;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [3:0]  cdb_data;
  logic [1:0]  cdb_src;

  typedef struct packed {
    logic [3:0] tag;
    logic [3:0] data;
    logic [1:0] src;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] tag_tab  [4];
  logic [3:0] data_tab [4];

  cdb_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(4), .CDB_TAG_WIDTH(4), .SRC_WIDTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_tag(req_tag),
    .req_data(req_data), .req_ready(req_ready), .cdb_stall(cdb_stall),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle: inputs applied just after the rising edge, ready and cdb_valid
  // checked once settled, and the expected broadcast queued for any granted producer.
  task automatic cycle(input logic [3:0] vld, input logic stall,
                       input logic [3:0] exp_rdy, input logic exp_cdb, input string name);
    req_valid = vld;
    cdb_stall = stall;
    #1;
    chk({name, "_ready"}, 32'(req_ready), 32'(exp_rdy));
    chk({name, "_cdb_valid"}, 32'(cdb_valid), 32'(exp_cdb));
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) exp_q.push_back('{tag: tag_tab[i], data: data_tab[i], src: 2'(i)});
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every broadcast must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && cdb_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_broadcast", 32'(cdb_valid), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("bcast_tag",  32'(cdb_tag),  32'(e.tag));
        chk("bcast_data", 32'(cdb_data), 32'(e.data));
        chk("bcast_src",  32'(cdb_src),  32'(e.src));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tag_tab  = '{4'h1, 4'h2, 4'h3, 4'h4};
    data_tab = '{4'h5, 4'h9, 4'hA, 4'hC};
    for (int i = 0; i < 4; i++) begin
      req_tag[i*4 +: 4]  = tag_tab[i];
      req_data[i*4 +: 4] = data_tab[i];
    end
    rst_n     = 1'b0;
    cdb_stall = 1'b0;
    req_valid = 4'b1111;

    // Reset state, with all producers requesting
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_valid", 32'(cdb_valid), 32'(0));
    chk("rst_tag",   32'(cdb_tag),   32'(0));
    chk("rst_data",  32'(cdb_data),  32'(0));
    chk("rst_src",   32'(cdb_src),   32'(0));
    rst_n = 1'b1;

`ifdef CDB_ARB_FIXED_PRIORITY_EN
    // Fixed priority: producer 0 always wins over producer 1
    cycle(4'b0011, 1'b0, 4'b0001, 1'b0, "fp0");
    cycle(4'b0011, 1'b0, 4'b0001, 1'b1, "fp1");
    cycle(4'b0011, 1'b0, 4'b0001, 1'b1, "fp2");
    cycle(4'b0010, 1'b0, 4'b0010, 1'b1, "fp3");
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, "fp4");
    cycle(4'b0110, 1'b0, 4'b0010, 1'b0, "fp5");
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, "fp6");
`else
    // Round-robin from reset, each producer drops valid after its transfer
    cycle(4'b1111, 1'b0, 4'b0001, 1'b0, "rr0");
    cycle(4'b1110, 1'b0, 4'b0010, 1'b1, "rr1");
    cycle(4'b1100, 1'b0, 4'b0100, 1'b1, "rr2");
    cycle(4'b1000, 1'b0, 4'b1000, 1'b1, "rr3");
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, "rr4");
    // Single producer 2 (tag 3, data A); pointer ends at 3
    cycle(4'b0100, 1'b0, 4'b0100, 1'b0, "single0");
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, "single1");
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, "single2");
    // Wrap-around from pointer 3: producer 3 then producer 0
    cycle(4'b1001, 1'b0, 4'b1000, 1'b0, "wrap0");
    cycle(4'b0001, 1'b0, 4'b0001, 1'b1, "wrap1");
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, "wrap2");
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, "wrap3");
    // Stall two cycles with producer 1 pending; pointer is 1
    cycle(4'b0010, 1'b1, 4'b0000, 1'b0, "stall0");
    cycle(4'b0010, 1'b1, 4'b0000, 1'b0, "stall1");
    cycle(4'b0010, 1'b0, 4'b0010, 1'b0, "stall2");
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, "stall3");
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, "stall4");
    // Pointer 2 with producers 1 and 2 pending: 2 wins first
    cycle(4'b0110, 1'b0, 4'b0100, 1'b0, "ptr0");
    cycle(4'b0010, 1'b0, 4'b0010, 1'b1, "ptr1");
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, "ptr2");
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, "ptr3");
    // Idle cycle keeps the last broadcast payload (producer 1)
    chk("hold_tag",  32'(cdb_tag),  32'(4'h2));
    chk("hold_data", 32'(cdb_data), 32'(4'h9));
    chk("hold_src",  32'(cdb_src),  32'(1));
    // Grant producer 2 (pointer moves to 3), then reset mid-broadcast
    req_valid = 4'b0100;
    #1;
    chk("pre_rst_ready", 32'(req_ready), 32'(4'b0100));
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    chk("pre_rst_valid", 32'(cdb_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("async_rst_valid", 32'(cdb_valid), 32'(0));
    chk("async_rst_tag",   32'(cdb_tag),   32'(0));
    chk("async_rst_data",  32'(cdb_data),  32'(0));
    chk("async_rst_src",   32'(cdb_src),   32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Pointer restarted at 0
    cycle(4'b1111, 1'b0, 4'b0001, 1'b0, "post_rst0");
    cycle(4'b0000, 1'b0, 4'b0000, 1'b1, "post_rst1");
`endif
    cycle(4'b0000, 1'b0, 4'b0000, 1'b0, "drain");
    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
